// File: rtl/nf2_dma_defs.sv
// Shared definitions for the NF2 DMA bus: opcodes, initiator FSM encoding, length field position.
// No logic of its own; imported by the initiator and its watchdog.
// Not applicable: no flow control lives here.
package nf2_dma_defs;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_TX   = 2'b01;
    localparam logic [1:0] OP_RX   = 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_TX_LEN  = 3'd2;
    localparam logic [2:0] ST_TX_DATA = 3'd3;
    localparam logic [2:0] ST_RX_LEN  = 3'd4;
    localparam logic [2:0] ST_RX_DATA = 3'd5;
    localparam logic [2:0] ST_FIN     = 3'd6;

    localparam int LEN_FIELD_MSB = 10;

endpackage

// File: rtl/cpci_dma_watchdog.sv
// Progress watchdog: counts enabled cycles without progress, flags saturation at all-ones.
// sat is combinational from the count; the count restarts the cycle after sat or clr.
// No back-pressure; disabled cycles hold the count at zero.
module cpci_dma_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic sat
);

    logic [TIMEOUT_W-1:0] cnt;

    assign sat = en && (&cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || clr || sat) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpci_dma_initiator.sv
// CPCI-side NF2 DMA initiator: one host TX push (c2n) or RX pull (n2c) command at a time.
// Request pins registered one cycle after accept; data words pass through combinationally.
// TX words stall on dma_dest_q_nearly_full_n2c / tx_valid; RX back-pressure is registered rx_nearly_full.
module cpci_dma_initiator
    import nf2_dma_defs::*;
#(
    parameter int DMA_DATA_WIDTH    = 32,
    parameter int NUM_CPU_QUEUES    = 4,
    parameter int PKT_LEN_CNT_WIDTH = 11,
    parameter int TIMEOUT_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_dir,
    input  logic [3:0]                   cmd_queue,
    input  logic [PKT_LEN_CNT_WIDTH-1:0] cmd_len,
    input  logic [DMA_DATA_WIDTH-1:0]    tx_data,
    input  logic                         tx_valid,
    output logic                         tx_rd,
    output logic [DMA_DATA_WIDTH-1:0]    rx_data,
    output logic                         rx_wr,
    input  logic                         rx_nearly_full,
    output logic                         done,
    output logic                         err,
    output logic [PKT_LEN_CNT_WIDTH-1:0] rx_len,
    output logic [1:0]                   dma_op_code_req,
    output logic [3:0]                   dma_op_queue_id,
    input  logic [1:0]                   dma_op_code_ack,
    output logic                         dma_vld_c2n,
    output logic [DMA_DATA_WIDTH-1:0]    dma_data_c2n,
    input  logic                         dma_dest_q_nearly_full_n2c,
    input  logic                         dma_vld_n2c,
    input  logic [DMA_DATA_WIDTH-1:0]    dma_data_n2c,
    output logic                         dma_dest_q_nearly_full_c2n,
    output logic                         dma_data_oe
);

    localparam int WL_W = PKT_LEN_CNT_WIDTH - 1;

    // Word count for a byte length, widened by one bit so 2047 + 3 does not wrap.
    function automatic logic [WL_W-1:0] len_words(input logic [PKT_LEN_CNT_WIDTH-1:0] len);
        logic [PKT_LEN_CNT_WIDTH:0] sum;
        sum = {1'b0, len} + (PKT_LEN_CNT_WIDTH+1)'(3);
        return sum[PKT_LEN_CNT_WIDTH:2];
    endfunction

    logic [2:0]                   state;
    logic [1:0]                   op_q;
    logic [1:0]                   req_q;
    logic [3:0]                   qid_q;
    logic [PKT_LEN_CNT_WIDTH-1:0] len_q;
    logic [PKT_LEN_CNT_WIDTH-1:0] rx_len_q;
    logic [WL_W-1:0]              words_left;
    logic                         err_lat;
    logic                         done_q;
    logic                         err_q;
    logic                         nf_c2n_q;

    logic cmd_bad;
    logic tx_len_go;
    logic tx_go;
    logic rx_go;
    logic ack_ok;
    logic wd_en;
    logic wd_clr;
    logic wd_sat;
    logic [PKT_LEN_CNT_WIDTH-1:0] rx_len_field;

    assign cmd_bad   = (32'(cmd_queue) >= NUM_CPU_QUEUES) || (!cmd_dir && (cmd_len == '0));
    assign tx_len_go = (state == ST_TX_LEN) && !dma_dest_q_nearly_full_n2c;
    assign tx_go     = (state == ST_TX_DATA) && tx_valid && !dma_dest_q_nearly_full_n2c;
    assign rx_go     = ((state == ST_RX_LEN) || (state == ST_RX_DATA)) && dma_vld_n2c;
    assign ack_ok    = ((state == ST_REQ) && (dma_op_code_ack == op_q)) ||
                       ((state == ST_FIN) && (dma_op_code_ack == OP_IDLE));
    assign wd_en     = (state == ST_REQ) || (state == ST_TX_DATA) || (state == ST_RX_LEN) ||
                       (state == ST_RX_DATA) || (state == ST_FIN);
    assign wd_clr    = ack_ok || tx_go || rx_go;
    assign rx_len_field = dma_data_n2c[PKT_LEN_CNT_WIDTH-1:0];

    // Gated by reset so every output reads 0 while reset_n is held low.
    assign cmd_ready  = reset_n && (state == ST_IDLE);
    assign tx_rd      = tx_go;
    assign dma_vld_c2n  = tx_go || tx_len_go;
    assign dma_data_c2n = tx_go     ? tx_data :
                          tx_len_go ? DMA_DATA_WIDTH'(len_q) : '0;
    assign dma_data_oe  = (state == ST_TX_LEN) || (state == ST_TX_DATA);
    assign rx_wr      = rx_go;
    assign rx_data    = rx_go ? dma_data_n2c : '0;
    assign done       = done_q;
    assign err        = err_q;
    assign rx_len     = rx_len_q;
    assign dma_op_code_req = req_q;
    assign dma_op_queue_id = qid_q;
    assign dma_dest_q_nearly_full_c2n = nf_c2n_q;

    cpci_dma_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (wd_en),
        .clr     (wd_clr),
        .sat     (wd_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_IDLE;
            req_q      <= OP_IDLE;
            qid_q      <= '0;
            len_q      <= '0;
            rx_len_q   <= '0;
            words_left <= '0;
            err_lat    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nf_c2n_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            nf_c2n_q <= rx_nearly_full;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            op_q    <= cmd_dir ? OP_RX : OP_TX;
                            req_q   <= cmd_dir ? OP_RX : OP_TX;
                            qid_q   <= cmd_queue;
                            len_q   <= cmd_len;
                            err_lat <= 1'b0;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dma_op_code_ack == op_q) begin
                        state <= (op_q == OP_TX) ? ST_TX_LEN : ST_RX_LEN;
                    end else if (wd_sat) begin
                        req_q   <= OP_IDLE;
                        err_lat <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_TX_LEN: begin
                    if (tx_len_go) begin
                        words_left <= len_words(len_q);
                        state      <= ST_TX_DATA;
                    end
                end
                ST_TX_DATA, ST_RX_DATA: begin
                    if (tx_go || rx_go) begin
                        words_left <= words_left - 1'b1;
                        if (words_left == WL_W'(1)) begin
                            req_q <= OP_IDLE;
                            state <= ST_FIN;
                        end
                    end else if (wd_sat) begin
                        req_q   <= OP_IDLE;
                        err_lat <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_RX_LEN: begin
                    if (rx_go) begin
                        rx_len_q   <= rx_len_field;
                        words_left <= len_words(rx_len_field);
                        if (rx_len_field == '0) begin
                            req_q   <= OP_IDLE;
                            err_lat <= 1'b1;
                            state   <= ST_FIN;
                        end else begin
                            state <= ST_RX_DATA;
                        end
                    end else if (wd_sat) begin
                        req_q   <= OP_IDLE;
                        err_lat <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // A responder that never releases its ack still gets the command retired.
                    if (ack_ok || wd_sat) begin
                        done_q <= 1'b1;
                        err_q  <= err_lat || !ack_ok;
                        qid_q  <= '0;
                        op_q   <= OP_IDLE;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpci_dma_initiator.sv
// Directed bench for cpci_dma_initiator: table of commands against a lagging-ack responder model,
// plus hand sequences for reset state, watchdog timeout, mid-transfer reset and RX back-pressure.
module tb_cpci_dma_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_dir;
    logic [3:0]  cmd_queue;
    logic [10:0] cmd_len;
    logic [31:0] tx_data;
    logic        tx_valid, tx_rd;
    logic [31:0] rx_data;
    logic        rx_wr, rx_nearly_full, done, err;
    logic [10:0] rx_len;
    logic [1:0]  dma_op_code_req, dma_op_code_ack;
    logic [3:0]  dma_op_queue_id;
    logic        dma_vld_c2n;
    logic [31:0] dma_data_c2n;
    logic        dma_dest_q_nearly_full_n2c, dma_vld_n2c;
    logic [31:0] dma_data_n2c;
    logic        dma_dest_q_nearly_full_c2n, dma_data_oe;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] prev_req = 2'b00;
    logic       ack_mute = 1'b0;

    always #5 clk = ~clk;

    cpci_dma_initiator #(
        .DMA_DATA_WIDTH(32), .NUM_CPU_QUEUES(4), .PKT_LEN_CNT_WIDTH(11), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_queue(cmd_queue), .cmd_len(cmd_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_rd(tx_rd),
        .rx_data(rx_data), .rx_wr(rx_wr), .rx_nearly_full(rx_nearly_full),
        .done(done), .err(err), .rx_len(rx_len),
        .dma_op_code_req(dma_op_code_req), .dma_op_queue_id(dma_op_queue_id),
        .dma_op_code_ack(dma_op_code_ack),
        .dma_vld_c2n(dma_vld_c2n), .dma_data_c2n(dma_data_c2n),
        .dma_dest_q_nearly_full_n2c(dma_dest_q_nearly_full_n2c),
        .dma_vld_n2c(dma_vld_n2c), .dma_data_n2c(dma_data_n2c),
        .dma_dest_q_nearly_full_c2n(dma_dest_q_nearly_full_c2n),
        .dma_data_oe(dma_data_oe)
    );

    typedef struct {
        logic        dir;
        logic [3:0]  q;
        logic [10:0] len;
        logic        stall;
        logic        exp_err;
        logic        exp_bus;
        int          exp_c2n;
        int          exp_rd;
        int          exp_rxwr;
        int          exp_rxlen;   // -1: not checked
        int          exp_lat;     // 0: not checked
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder ack model: echoes the request one cycle late unless muted.
    task automatic tick();
        @(posedge clk);
        #1;
        dma_op_code_ack = ack_mute ? 2'b00 : prev_req;
        prev_req = dma_op_code_req;
    endtask

    function automatic logic [31:0] out_vec();
        return {cmd_ready, tx_rd, rx_wr, done, err, dma_vld_c2n, dma_data_oe,
                dma_dest_q_nearly_full_c2n, dma_op_code_req, dma_op_queue_id};
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int c2n_n = 0, rd_n = 0, rxwr_n = 0, c2n_bad = 0, rx_bad = 0;
        int stall_left = 0, stall_vld = 0, oe_bad = 0, qid_bad = 0, rsvd = 0;
        int tx_idx = 0, rx_sent = 0, rx_total, lat = 0, cyc = 1;
        logic bus = 1'b0, rx_started = 1'b0, stall_used = 1'b0, got_done = 1'b0, got_err = 1'b0;
        logic [31:0] exp_w;
        rx_total = 1 + ((int'(v.len) + 3) >> 2);
        cmd_valid = 1'b1;
        cmd_dir   = v.dir;
        cmd_queue = v.q;
        cmd_len   = v.dir ? 11'd0 : v.len;
        #3;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        while (!got_done && cyc < 3000) begin
            tx_valid = !v.dir;
            tx_data  = 32'hA000_0000 + tx_idx;
            if (v.stall && !stall_used && c2n_n == 6) begin
                stall_used = 1'b1;
                stall_left = 5;
            end
            dma_dest_q_nearly_full_n2c = (stall_left > 0);
            dma_vld_n2c  = rx_started && (rx_sent < rx_total);
            dma_data_n2c = (rx_sent == 0) ? {21'd0, v.len} : 32'hB000_0000 + rx_sent;
            #3;
            if (dma_vld_n2c) rx_sent++;
            if (dma_vld_c2n) begin
                exp_w = (c2n_n == 0) ? {21'd0, v.len} : 32'hA000_0000 + (c2n_n - 1);
                if (dma_data_c2n !== exp_w) c2n_bad++;
                c2n_n++;
            end
            if (stall_left > 0) begin
                if (dma_vld_c2n || tx_rd) stall_vld++;
                stall_left--;
            end
            if (tx_rd) begin
                rd_n++;
                tx_idx++;
            end
            if (rx_wr) begin
                exp_w = (rxwr_n == 0) ? {21'd0, v.len} : 32'hB000_0000 + rxwr_n;
                if (rx_data !== exp_w) rx_bad++;
                rxwr_n++;
            end
            if (dma_op_code_req != 2'b00) bus = 1'b1;
            if (dma_op_code_req == 2'b11) rsvd++;
            if (dma_op_code_req != 2'b00 && dma_op_queue_id != v.q) qid_bad++;
            if (dma_vld_c2n && !dma_data_oe) oe_bad++;
            if (v.dir && dma_data_oe) oe_bad++;
            if (v.dir && dma_op_code_ack == 2'b10) rx_started = 1'b1;
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
                lat      = cyc;
            end else begin
                tick();
                cyc++;
            end
        end
        check({tag, "_done"}, got_done, 1);
        check({tag, "_err"}, got_err, v.exp_err);
        check({tag, "_bus_used"}, bus, v.exp_bus);
        check({tag, "_c2n_words"}, c2n_n, v.exp_c2n);
        check({tag, "_tx_rd"}, rd_n, v.exp_rd);
        check({tag, "_rx_wr"}, rxwr_n, v.exp_rxwr);
        check({tag, "_order"}, c2n_bad + rx_bad, 0);
        check({tag, "_pins"}, stall_vld + oe_bad + qid_bad + rsvd, 0);
        if (v.exp_rxlen >= 0) check({tag, "_rx_len"}, rx_len, v.exp_rxlen);
        if (v.exp_lat > 0)    check({tag, "_latency"}, lat, v.exp_lat);
        tx_valid = 1'b0;
        dma_vld_n2c = 1'b0;
        dma_dest_q_nearly_full_n2c = 1'b0;
        tick();
    endtask

    initial begin
        int req_cycles, lat, c2n_n;
        logic got_done, got_err;
        //            dir  q      len      stl  err  bus  c2n  rd   rxwr rxlen lat
        vecs[0] = '{1'b0, 4'd2, 11'd9,    1'b0, 1'b0, 1'b1, 4,   3,   0,   -1,   0};
        vecs[1] = '{1'b1, 4'd1, 11'd60,   1'b0, 1'b0, 1'b1, 0,   0,   16,  60,   0};
        vecs[2] = '{1'b0, 4'd3, 11'd64,   1'b1, 1'b0, 1'b1, 17,  16,  0,   -1,   0};
        vecs[3] = '{1'b0, 4'd5, 11'd9,    1'b0, 1'b1, 1'b0, 0,   0,   0,   -1,   1};
        vecs[4] = '{1'b0, 4'd0, 11'd0,    1'b0, 1'b1, 1'b0, 0,   0,   0,   -1,   1};
        vecs[5] = '{1'b1, 4'd5, 11'd4,    1'b0, 1'b1, 1'b0, 0,   0,   0,   -1,   1};
        vecs[6] = '{1'b1, 4'd0, 11'd0,    1'b0, 1'b1, 1'b1, 0,   0,   1,   0,    0};
        vecs[7] = '{1'b0, 4'd1, 11'd1,    1'b0, 1'b0, 1'b1, 2,   1,   0,   -1,   0};
        vecs[8] = '{1'b0, 4'd0, 11'd2047, 1'b0, 1'b0, 1'b1, 513, 512, 0,   -1,   0};
        vecs[9] = '{1'b1, 4'd3, 11'd5,    1'b0, 1'b0, 1'b1, 0,   0,   3,   5,    0};

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_queue = 4'd0; cmd_len = 11'd0;
        tx_data = 32'd0; tx_valid = 1'b0; rx_nearly_full = 1'b0;
        dma_op_code_ack = 2'b00; dma_dest_q_nearly_full_n2c = 1'b0;
        dma_vld_n2c = 1'b0; dma_data_n2c = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 0);
        check("reset_data", dma_data_c2n | rx_data | 32'(rx_len), 0);
        reset_n = 1'b1;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // RX back-pressure is a registered copy of rx_nearly_full.
        rx_nearly_full = 1'b1;
        #3;
        check("nf_c2n_lag", dma_dest_q_nearly_full_c2n, 0);
        tick();
        check("nf_c2n_set", dma_dest_q_nearly_full_c2n, 1);
        rx_nearly_full = 1'b0;
        tick();
        check("nf_c2n_clr", dma_dest_q_nearly_full_c2n, 0);

        // Ack never returned: 16 REQ cycles (count 0..15), FIN, then done with err.
        ack_mute = 1'b1;
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_queue = 4'd0; cmd_len = 11'd4;
        tick();
        cmd_valid = 1'b0;
        tx_valid = 1'b1;
        req_cycles = 0; lat = 0; c2n_n = 0; got_done = 1'b0; got_err = 1'b0;
        for (int cyc = 1; cyc < 200 && !got_done; cyc++) begin
            #3;
            if (dma_op_code_req == 2'b01) req_cycles++;
            if (dma_vld_c2n) c2n_n++;
            if (done) begin
                got_done = 1'b1;
                got_err = err;
                lat = cyc;
            end else begin
                tick();
            end
        end
        check("to_req_cycles", req_cycles, 16);
        check("to_done", got_done, 1);
        check("to_err", got_err, 1);
        check("to_latency", lat, 18);
        check("to_no_words", c2n_n, 0);
        tx_valid = 1'b0;
        ack_mute = 1'b0;
        tick();

        // Reset asserted in the middle of TX_DATA.
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_queue = 4'd1; cmd_len = 11'd40;
        tick();
        cmd_valid = 1'b0;
        tx_valid = 1'b1;
        c2n_n = 0;
        for (int cyc = 0; cyc < 100 && c2n_n < 4; cyc++) begin
            tx_data = 32'h5500_0000 + c2n_n;
            #3;
            if (dma_vld_c2n) c2n_n++;
            tick();
        end
        check("rst_mid_reached", c2n_n, 4);
        check("rst_mid_active", dma_data_oe, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", out_vec(), 0);
        check("rst_mid_data", dma_data_c2n, 0);
        tx_valid = 1'b0;
        dma_op_code_ack = 2'b00;
        prev_req = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        run_cmd(vecs[0], "post_rst_tx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
